// File: rtl/tactile_scan_ctrl.sv
// tactile_scan_ctrl
//
// Scans a tactile sensor grid one pixel at a time. For each pixel it selects
// a switch wire and a read wire, waits for the analog path to settle,
// requests one ADC conversion, and then presents the 12-bit sample together
// with its pixel address. Scans one frame per start pulse, or scans
// back-to-back frames while 'continuous' is high. A missing ADC ack is
// recovered by timeout, and completed frames are counted.
//
// Optional build macro TACTILE_BASELINE_SUB_EN:
//   Adds input 'cal' and a per-pixel baseline RAM. A calibration frame stores
//   its raw samples as the baseline. Other frames output
//   max(sample - baseline, 0). The pixel outputs and frame_done then come out
//   through one register stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, accepted only in IDLE
//   continuous          sampled in DONE: 1 = scan again, 0 = go idle
//   sw_sel, rd_sel      active switch / read wire indices
//   sw_en               analog mux enable (SELECT, CONVERT)
//   adc_req / adc_ack   conversion handshake, adc_data valid with ack
//   pix_valid           one-cycle strobe with pix_addr / pix_data
//   busy                high outside IDLE
//   frame_done          one-cycle pulse at end of frame
//   frame_cnt           completed frames since reset (wraps)
//   err_timeout         sticky ADC timeout flag, cleared by reset or accepted start
//   cal                 (TACTILE_BASELINE_SUB_EN only) calibration frame select
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// SELECT  | wires selected, settling for SETTLE_CYCLES clocks
// CONVERT | adc_req held until ack or ADC_TIMEOUT clocks elapse
// STORE   | pixel strobe, advance indices
// DONE    | frame_done pulse, restart or return to IDLE

module tactile_scan_ctrl #(
   parameter int SW_WIRE_CNT   = 16,
   parameter int RD_WIRE_CNT   = 16,
   parameter int SETTLE_CYCLES = 8,
   parameter int ADC_TIMEOUT   = 255
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       start,
   input  logic                                       continuous,
`ifdef TACTILE_BASELINE_SUB_EN
   input  logic                                       cal,
`endif
   output logic [$clog2(SW_WIRE_CNT)-1:0]             sw_sel,
   output logic [$clog2(RD_WIRE_CNT)-1:0]             rd_sel,
   output logic                                       sw_en,
   output logic                                       adc_req,
   input  logic                                       adc_ack,
   input  logic [11:0]                                adc_data,
   output logic                                       pix_valid,
   output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0] pix_addr,
   output logic [11:0]                                pix_data,
   output logic                                       busy,
   output logic                                       frame_done,
   output logic [15:0]                                frame_cnt,
   output logic                                       err_timeout
);

   localparam int SW_W = $clog2(SW_WIRE_CNT);
   localparam int RD_W = $clog2(RD_WIRE_CNT);
   localparam int NPIX = SW_WIRE_CNT * RD_WIRE_CNT;
   localparam int PA_W = $clog2(NPIX);
   localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TO_W = $clog2(ADC_TIMEOUT + 1);

   localparam logic [SW_W-1:0] SW_LAST      = SW_W'(SW_WIRE_CNT - 1);
   localparam logic [RD_W-1:0] RD_LAST      = RD_W'(RD_WIRE_CNT - 1);
   localparam logic [ST_W-1:0] SETTLE_LOAD  = ST_W'(SETTLE_CYCLES - 1);
   localparam logic [TO_W-1:0] TIMEOUT_LOAD = TO_W'(ADC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_CONVERT,
      S_STORE,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ST_W-1:0]   settle_cnt;
   logic [TO_W-1:0]   wait_cnt;
   logic [11:0]       cap_data;
   logic              store_pix;
   logic              done_pulse;
   logic              last_pix;
   logic [PA_W-1:0]   addr_raw;

   assign last_pix = (sw_sel == SW_LAST) && (rd_sel == RD_LAST);
   assign addr_raw = PA_W'(int'(sw_sel) * RD_WIRE_CNT + int'(rd_sel));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      sw_en      = 1'b0;
      adc_req    = 1'b0;
      store_pix  = 1'b0;
      done_pulse = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_SELECT;
         end
         S_SELECT: begin
            sw_en = 1'b1;
            if (settle_cnt == '0) state_nxt = S_CONVERT;
         end
         S_CONVERT: begin
            sw_en   = 1'b1;
            adc_req = 1'b1;
            if (adc_ack || (wait_cnt == '0)) state_nxt = S_STORE;
         end
         S_STORE: begin
            store_pix = 1'b1;
            state_nxt = last_pix ? S_DONE : S_SELECT;
         end
         S_DONE: begin
            done_pulse = 1'b1;
            state_nxt  = continuous ? S_SELECT : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Both timers reload whenever their state is not active, so they always
   // hold a fresh terminal count on entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_sel      <= '0;
         rd_sel      <= '0;
         settle_cnt  <= '0;
         wait_cnt    <= '0;
         cap_data    <= '0;
         frame_cnt   <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state != S_SELECT)    settle_cnt <= SETTLE_LOAD;
         else if (settle_cnt != '0) settle_cnt <= settle_cnt - ST_W'(1);

         if (state != S_CONVERT)   wait_cnt <= TIMEOUT_LOAD;
         else if (wait_cnt != '0) wait_cnt <= wait_cnt - TO_W'(1);

         case (state)
            S_IDLE: begin
               if (start) begin
                  sw_sel      <= '0;
                  rd_sel      <= '0;
                  err_timeout <= 1'b0;
               end
            end
            S_CONVERT: begin
               if (adc_ack) begin
                  cap_data <= adc_data;
               end else if (wait_cnt == '0) begin
                  cap_data    <= '0;
                  err_timeout <= 1'b1;
               end
            end
            S_STORE: begin
               if (rd_sel == RD_LAST) begin
                  rd_sel <= '0;
                  sw_sel <= (sw_sel == SW_LAST) ? '0 : sw_sel + SW_W'(1);
               end else begin
                  rd_sel <= rd_sel + RD_W'(1);
               end
            end
            S_DONE: frame_cnt <= frame_cnt + 16'd1;
            default: ;
         endcase
      end
   end

`ifdef TACTILE_BASELINE_SUB_EN
   logic        cal_frame;
   logic [11:0] baseline [NPIX];
   logic [12:0] diff;

   assign diff = {1'b0, cap_data} - {1'b0, baseline[addr_raw]};

   always_ff @(posedge clk) begin
      if (rst) begin
         cal_frame  <= 1'b0;
         pix_valid  <= 1'b0;
         pix_addr   <= '0;
         pix_data   <= '0;
         frame_done <= 1'b0;
         for (int i = 0; i < NPIX; i++) baseline[i] <= '0;
      end else begin
         if (((state == S_IDLE) && start) || ((state == S_DONE) && continuous))
            cal_frame <= cal;
         if (store_pix && cal_frame) baseline[addr_raw] <= cap_data;
         pix_valid  <= store_pix;
         pix_addr   <= addr_raw;
         frame_done <= done_pulse;
         if (store_pix)
            pix_data <= (cal_frame || diff[12]) ? (cal_frame ? cap_data : 12'd0) : diff[11:0];
      end
   end
`else
   assign pix_valid  = store_pix;
   assign pix_addr   = addr_raw;
   assign pix_data   = cap_data;
   assign frame_done = done_pulse;
`endif

endmodule
